reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 17 +
 rtl/word_ser.sv | 34 +++
 rtl/reg_dump.sv | 98 +++++++++
 tb/tb_reg_dump.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump block: FSM state encoding and stream geometry.
package reg_dump_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int IDX_W          = 5;
   localparam int CNT_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND,
      FIN
   } dumpState_e;

endpackage

// File: rtl/word_ser.sv
// Captures a 32-bit word and presents it one byte at a time, MSB first.
module word_ser
   import reg_dump_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] wordIn,
   output logic [BYTE_W-1:0] byteOut,
   output logic              lastByte
);

   logic [WORD_W-1:0] shiftReg;
   logic [CNT_W-1:0]  byteCnt;

   assign lastByte = (byteCnt == CNT_W'(BYTES_PER_WORD - 1));
   assign byteOut  = shiftReg[WORD_W-1 -: BYTE_W];

   // The count saturates on the last byte; only a fresh load brings it back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shiftReg <= '0;
         byteCnt  <= '0;
      end else if (load) begin
         shiftReg <= wordIn;
         byteCnt  <= '0;
      end else if (shift && !lastByte) begin
         shiftReg <= {shiftReg[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
         byteCnt  <= byteCnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/reg_dump.sv
// Streams registers FIRST_REG..LAST_REG from a register-file read port as an MSB-first byte stream.
module reg_dump
   import reg_dump_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [IDX_W-1:0]  rd_addr,
   input  logic [WORD_W-1:0] rd_data,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

   dumpState_e        state;
   dumpState_e        nextState;
   logic [IDX_W-1:0]  idx;
   logic              xfer;
   logic              lastByte;
   logic [BYTE_W-1:0] serByte;

   // Abort wins over a transfer offered on the same edge.
   assign xfer = (state == SEND) && out_ready && !abort;

   word_ser u_word_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == LOAD),
      .shift    (xfer),
      .wordIn   (rd_data),
      .byteOut  (serByte),
      .lastByte (lastByte)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: nextState gets its default before the case so no path can leave it unassigned (no latch).
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = LOAD;
            end
         end
         LOAD: begin
            nextState = abort ? IDLE : SEND;
         end
         SEND: begin
            if (abort) begin
               nextState = IDLE;
            end else if (xfer && lastByte) begin
               nextState = (idx == LAST_IDX) ? FIN : LOAD;
            end
         end
         FIN: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // idx returns to FIRST_REG whenever the FSM heads back to IDLE, so a restart always begins there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= FIRST_IDX;
      end else if (nextState == IDLE) begin
         idx <= FIRST_IDX;
      end else if (state == SEND && nextState == LOAD) begin
         idx <= idx + IDX_W'(1);
      end
   end

   assign rd_addr   = (state == IDLE) ? FIRST_IDX : idx;
   assign out_valid = (state == SEND);
   assign out_data  = out_valid ? serByte : '0;
   assign busy      = (state != IDLE);
   assign done      = (state == FIN) && !abort;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dump, back-pressure, register window, abort, snapshot, reset.
`timescale 1ns/1ps
module tb_reg_dump;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] regs [32];

   logic        start1, abort1, ready1, valid1, busy1, done1;
   logic [4:0]  addr1;
   logic [31:0] data1;
   logic [7:0]  byte1;

   logic        start2, abort2, ready2, valid2, busy2, done2;
   logic [4:0]  addr2;
   logic [31:0] data2;
   logic [7:0]  byte2;

   bit          sel;
   logic        selValid, selBusy, selDone;
   logic [7:0]  selData;

   int          total = 0;
   int          bad   = 0;

   logic [7:0]  gotBytes [256];
   logic [7:0]  expBytes [256];
   int          nBytes, expN, doneAt, doneCount, firstValidAt, lastXferAt;

   always #5 clk = ~clk;

   assign data1 = regs[addr1];
   assign data2 = regs[addr2];

   assign selValid = sel ? valid2 : valid1;
   assign selBusy  = sel ? busy2  : busy1;
   assign selDone  = sel ? done2  : done1;
   assign selData  = sel ? byte2  : byte1;

   reg_dump dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .abort     (abort1),
      .rd_addr   (addr1),
      .rd_data   (data1),
      .out_data  (byte1),
      .out_valid (valid1),
      .out_ready (ready1),
      .busy      (busy1),
      .done      (done1)
   );

   reg_dump #(.FIRST_REG(5), .LAST_REG(6)) dut_win (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .abort     (abort2),
      .rd_addr   (addr2),
      .rd_data   (data2),
      .out_data  (byte2),
      .out_valid (valid2),
      .out_ready (ready2),
      .busy      (busy2),
      .done      (done2)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic build_exp(input int first, input int last);
      expN = 0;
      for (int r = first; r <= last; r++) begin
         for (int b = 0; b < 4; b++) begin
            expBytes[expN] = regs[r][31 - 8*b -: 8];
            expN++;
         end
      end
   endtask

   task automatic check_byte(input string name, input int pos, input logic [7:0] want);
      total++;
      if (gotBytes[pos] !== want) begin
         bad++;
         $display("FAIL %s byte[%0d]: got=%h want=%h", name, pos, gotBytes[pos], want);
      end
   endtask

   // Start a dump and follow it cycle by cycle. Iteration i samples just after edge N+i,
   // where N is the edge that saw start; ready driven in iteration i applies to edge N+i+1.
   task automatic run_dump(input bit useSecond, input bit toggleReady, input int writeAt,
                           input logic [31:0] writeVal, input int abortAt, input int pokeAt,
                           input int limit);
      logic       prevStall;
      logic [7:0] prevByte;
      logic       readyNow;
      sel          = useSecond;
      nBytes       = 0;
      doneAt       = -1;
      doneCount    = 0;
      firstValidAt = -1;
      lastXferAt   = -1;
      prevStall    = 1'b0;
      prevByte     = '0;
      @(negedge clk);
      if (useSecond) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clk);
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         start1 = 1'b0;
         start2 = 1'b0;
         abort1 = 1'b0;
         if (i == pokeAt) begin
            if (useSecond) start2 = 1'b1; else start1 = 1'b1;
         end
         if (i == writeAt) regs[2] = writeVal;
         if (i == abortAt) abort1 = 1'b1;
         readyNow = toggleReady ? (i % 3 == 0) : 1'b1;
         ready1   = readyNow;
         ready2   = readyNow;
         #1;
         if (selValid && firstValidAt < 0) firstValidAt = i;
         if (selDone) begin
            doneCount++;
            if (doneAt < 0) doneAt = i;
         end
         if (prevStall && selValid) begin
            total++;
            if (selData !== prevByte) begin
               bad++;
               $display("FAIL stall_hold i=%0d: got=%h want=%h", i, selData, prevByte);
            end
         end
         if (i == abortAt + 1) begin
            total++;
            if (selValid !== 1'b0 || selBusy !== 1'b0 || selDone !== 1'b0) begin
               bad++;
               $display("FAIL abort_idle: valid=%b busy=%b done=%b want 0 0 0",
                        selValid, selBusy, selDone);
            end
         end
         if (selValid && readyNow && i != abortAt && nBytes < 256) begin
            gotBytes[nBytes] = selData;
            nBytes++;
            lastXferAt = i;
         end
         prevStall = selValid && !readyNow;
         prevByte  = selData;
         if (doneAt >= 0 && i >= doneAt + 2) break;
      end
      ready1 = 1'b1;
      ready2 = 1'b1;
   endtask

   task automatic test_reset;
      rst_n  = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
      start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b1;
      for (int r = 0; r < 32; r++) regs[r] = '0;
      repeat (3) @(negedge clk);
      total++;
      if (valid1 !== 1'b0 || byte1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: valid=%b data=%h busy=%b done=%b want 0 00 0 0",
                  valid1, byte1, busy1, done1);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (addr1 !== 5'd0) begin
         bad++;
         $display("FAIL idle_addr: got=%0d want=0", addr1);
      end
      total++;
      if (addr2 !== 5'd5 || busy2 !== 1'b0 || valid2 !== 1'b0) begin
         bad++;
         $display("FAIL idle_win: addr=%0d busy=%b valid=%b want 5 0 0", addr2, busy2, valid2);
      end
   endtask

   task automatic test_full_dump;
      regs[1]  = 32'h11223344;
      regs[31] = 32'hDEADBEEF;
      build_exp(0, 31);
      run_dump(1'b0, 1'b0, -1, '0, -10, -10, 200);
      total++;
      if (nBytes !== 128) begin bad++; $display("FAIL full_count: got=%0d want=128", nBytes); end
      total++;
      if (firstValidAt !== 1) begin bad++; $display("FAIL first_valid: got=%0d want=1", firstValidAt); end
      total++;
      if (doneAt !== 160) begin bad++; $display("FAIL done_latency: got=%0d want=160", doneAt); end
      total++;
      if (doneCount !== 1) begin bad++; $display("FAIL done_pulses: got=%0d want=1", doneCount); end
      check_byte("r1", 4, 8'h11); check_byte("r1", 5, 8'h22);
      check_byte("r1", 6, 8'h33); check_byte("r1", 7, 8'h44);
      check_byte("r31", 124, 8'hDE); check_byte("r31", 125, 8'hAD);
      check_byte("r31", 126, 8'hBE); check_byte("r31", 127, 8'hEF);
      for (int k = 0; k < 128; k++) check_byte("full_model", k, expBytes[k]);
   endtask

   task automatic test_back_to_back_stall;
      build_exp(0, 31);
      run_dump(1'b0, 1'b1, -1, '0, -10, 20, 1000);
      total++;
      if (nBytes !== 128) begin bad++; $display("FAIL stall_count: got=%0d want=128", nBytes); end
      for (int k = 0; k < 128; k++) check_byte("stall_model", k, expBytes[k]);
      total++;
      if (doneCount !== 1 || doneAt !== lastXferAt + 1) begin
         bad++;
         $display("FAIL stall_done: pulses=%0d at=%0d want 1 at %0d", doneCount, doneAt, lastXferAt + 1);
      end
      total++;
      if (busy1 !== 1'b0) begin bad++; $display("FAIL start_not_queued: busy=%b want 0", busy1); end
   endtask

   task automatic test_window;
      regs[5] = 32'hA5A5A5A5;
      regs[6] = 32'h0000FFFF;
      run_dump(1'b1, 1'b0, -1, '0, -10, -10, 40);
      total++;
      if (nBytes !== 8) begin bad++; $display("FAIL win_count: got=%0d want=8", nBytes); end
      check_byte("win", 0, 8'hA5); check_byte("win", 1, 8'hA5);
      check_byte("win", 2, 8'hA5); check_byte("win", 3, 8'hA5);
      check_byte("win", 4, 8'h00); check_byte("win", 5, 8'h00);
      check_byte("win", 6, 8'hFF); check_byte("win", 7, 8'hFF);
      total++;
      if (doneAt !== 10 || doneCount !== 1) begin
         bad++;
         $display("FAIL win_done: at=%0d pulses=%0d want 10 1", doneAt, doneCount);
      end
      regs[5] = '0;
      regs[6] = '0;
   endtask

   task automatic test_abort;
      regs[0] = 32'hCAFEF00D;
      regs[3] = 32'h0A0B0C0D;
      // r3 is captured at edge N+16, so its second byte is on offer in iteration 17.
      run_dump(1'b0, 1'b0, -1, '0, 17, -10, 30);
      total++;
      if (nBytes !== 13) begin bad++; $display("FAIL abort_count: got=%0d want=13", nBytes); end
      check_byte("abort_r0", 0, 8'hCA); check_byte("abort_r0", 3, 8'h0D);
      check_byte("abort_r3", 12, 8'h0A);
      total++;
      if (doneCount !== 0) begin bad++; $display("FAIL abort_no_done: got=%0d want=0", doneCount); end
      run_dump(1'b0, 1'b0, -1, '0, -10, -10, 200);
      total++;
      if (nBytes !== 128) begin bad++; $display("FAIL restart_count: got=%0d want=128", nBytes); end
      check_byte("restart_r0", 0, 8'hCA); check_byte("restart_r0", 1, 8'hFE);
      check_byte("restart_r0", 2, 8'hF0); check_byte("restart_r0", 3, 8'h0D);
      check_byte("restart_r3", 12, 8'h0A); check_byte("restart_r3", 15, 8'h0D);
      regs[0] = '0;
      regs[3] = '0;
   endtask

   task automatic test_snapshot;
      regs[2] = '0;
      // r2 is captured at edge N+11; the write lands right after that edge.
      run_dump(1'b0, 1'b0, 11, 32'h12345678, -10, -10, 200);
      for (int k = 8; k < 12; k++) check_byte("snap_old", k, 8'h00);
      run_dump(1'b0, 1'b0, -1, '0, -10, -10, 200);
      check_byte("snap_new", 8, 8'h12); check_byte("snap_new", 9, 8'h34);
      check_byte("snap_new", 10, 8'h56); check_byte("snap_new", 11, 8'h78);
      regs[2] = '0;
   endtask

   task automatic test_idle_abort_and_reset;
      sel = 1'b0;
      @(negedge clk);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      #1;
      total++;
      if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
         bad++;
         $display("FAIL idle_abort: busy=%b valid=%b want 0 0", busy1, valid1);
      end
      start1 = 1'b1;
      abort1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      abort1 = 1'b0;
      #1;
      total++;
      if (busy1 !== 1'b1 || addr1 !== 5'd0) begin
         bad++;
         $display("FAIL abort_with_start: busy=%b addr=%0d want 1 0", busy1, addr1);
      end
      repeat (3) @(negedge clk);
      #2;
      total++;
      if (valid1 !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got=%b want 1", valid1); end
      rst_n = 1'b0;
      #1;
      total++;
      if (valid1 !== 1'b0 || byte1 !== 8'h00 || busy1 !== 1'b0 || done1 !== 1'b0 || addr1 !== 5'd0) begin
         bad++;
         $display("FAIL async_reset: valid=%b data=%h busy=%b done=%b addr=%0d want 0 00 0 0 0",
                  valid1, byte1, busy1, done1, addr1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (busy1 !== 1'b0 || valid1 !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", busy1, valid1);
      end
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_back_to_back_stall();
      test_window();
      test_abort();
      test_snapshot();
      test_idle_abort_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
